// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bus_pkg
// Purpose  : Shared widths, target-ID field position and FSM state encoding
//            for the serial-bus target port.
// Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;

    // Address bits compared against the target identifier
    localparam int TID_MSB = 15;
    localparam int TID_LSB = 12;

    // Bit counter wide enough for the longer (address) field
    localparam int BCNT_W  = $clog2(ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_WRITE = 3'd3,
        S_RWAIT = 3'd4,
        S_SPLIT = 3'd5,
        S_RTX   = 3'd6,
        S_ACK   = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/target_port_if.sv
`default_nettype none
// ============================================================================
// Interface : target_port_if
// Purpose   : Serial-bus control strobes between initiator and target.
//             The bidirectional data line itself stays a plain inout on the
//             target so its tristate driver sits at a module boundary.
// Signals   : bus_data_out_valid - initiator bit strobe
//             bus_mode           - 0 address phase, 1 data phase
//             bus_init_rw        - 1 write, 0 read
//             split_grant        - bus re-granted for split read return
//             bus_data_in_valid  - target bit strobe while it drives bus_data
// Revision  : 1.0 - initial release
// ============================================================================
interface target_port_if;

    logic bus_data_out_valid;
    logic bus_mode;
    logic bus_init_rw;
    logic split_grant;
    logic bus_data_in_valid;

    modport master (
        output bus_data_out_valid,
        output bus_mode,
        output bus_init_rw,
        output split_grant,
        input  bus_data_in_valid
    );

    modport slave (
        input  bus_data_out_valid,
        input  bus_mode,
        input  bus_init_rw,
        input  split_grant,
        output bus_data_in_valid
    );

endinterface
`default_nettype wire

// File: rtl/target_serializer.sv
`default_nettype none
// ============================================================================
// Module   : target_serializer
// Purpose  : Load-and-shift transmitter. A load pulse starts an LSB-first
//            burst of DATA_W bits on consecutive cycles; bit and strobe are
//            both registered so they stay aligned.
// Ports    : clk, rst_n         - clock, async active-low reset
//            load, load_data    - start a burst with this byte
//            tx_bit, tx_valid   - bit being driven and its strobe
//            tx_last            - high while the final bit is on the line
// Revision : 1.0 - initial release
// ============================================================================
module target_serializer
    import bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_last
);

    localparam int REM_W = $clog2(DATA_W);

    // Bits still waiting behind the one currently on tx_bit
    logic [DATA_W-2:0] r_shift;
    logic [REM_W-1:0]  r_remain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_bit   <= 1'b0;
            tx_valid <= 1'b0;
            r_shift  <= '0;
            r_remain <= '0;
        end else if (load) begin
            tx_bit   <= load_data[0];
            tx_valid <= 1'b1;
            r_shift  <= load_data[DATA_W-1:1];
            r_remain <= REM_W'(DATA_W - 1);
        end else if (tx_valid) begin
            if (r_remain == '0) begin
                tx_valid <= 1'b0;
                tx_bit   <= 1'b0;
            end else begin
                tx_bit   <= r_shift[0];
                r_shift  <= {1'b0, r_shift[DATA_W-2:1]};
                r_remain <= r_remain - 1'b1;
            end
        end
    end

    assign tx_last = tx_valid && (r_remain == '0);

endmodule
`default_nettype wire

// File: rtl/target_port.sv
`default_nettype none
// ============================================================================
// Module   : target_port
// Purpose  : Serial-bus target. Receives a 16-bit address LSB first, decodes
//            addr[15:12] against TARGET_ID, then either assembles 8 write
//            bits and strobes target_wr, or strobes target_rd and returns
//            the read byte serially, signalling a split if the local memory
//            is slower than SPLIT_TIMEOUT cycles.
// Ports    : clk, rst_n              - clock, async active-low reset
//            bus_data                - bidirectional serial line
//            bif                     - bus strobes (slave modport)
//            target_rdata/_valid     - local read return
//            target_addr/_wdata      - latched address / write data
//            target_wr, target_rd    - one-cycle memory strobes
//            target_ack, target_split- one-cycle completion / split pulses
// Revision : 1.0 - initial release
// ============================================================================
module target_port
    import bus_pkg::*;
#(
    parameter logic [3:0] TARGET_ID     = 4'h1,
    parameter int         SPLIT_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire               bus_data,
    target_port_if.slave      bif,
    input  logic [DATA_W-1:0] target_rdata,
    input  logic              target_rdata_valid,
    output logic [ADDR_W-1:0] target_addr,
    output logic [DATA_W-1:0] target_wdata,
    output logic              target_wr,
    output logic              target_rd,
    output logic              target_ack,
    output logic              target_split
);

    localparam int CNT_W = $clog2(SPLIT_TIMEOUT + 1);

    state_t              r_state;
    logic [BCNT_W-1:0]   r_bit_cnt;
    logic [ADDR_W-2:0]   r_addr_sh;   // first 15 address bits received
    logic [DATA_W-2:0]   r_data_sh;   // first 7 write bits received
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [DATA_W-1:0]   r_rdata;     // read byte held across a split
    logic                r_have_data;

    logic                w_addr_stb;
    logic                w_data_stb;
    logic [ADDR_W-1:0]   w_addr_full;
    logic [DATA_W-1:0]   w_data_full;
    logic                w_ser_load;
    logic [DATA_W-1:0]   w_ser_data;
    logic                w_tx_bit;
    logic                w_tx_valid;
    logic                w_tx_last;

    assign w_addr_stb  = bif.bus_data_out_valid && !bif.bus_mode;
    assign w_data_stb  = bif.bus_data_out_valid &&  bif.bus_mode;

    // Complete words including the bit arriving this cycle (LSB first)
    assign w_addr_full = {bus_data, r_addr_sh};
    assign w_data_full = {bus_data, r_data_sh};

    // A split return needs both a captured byte (now or earlier) and the grant
    assign w_ser_load  = ((r_state == S_RWAIT) && target_rdata_valid) ||
                         ((r_state == S_SPLIT) && bif.split_grant &&
                          (target_rdata_valid || r_have_data));
    assign w_ser_data  = target_rdata_valid ? target_rdata : r_rdata;

    target_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_ser_load),
        .load_data (w_ser_data),
        .tx_bit    (w_tx_bit),
        .tx_valid  (w_tx_valid),
        .tx_last   (w_tx_last)
    );

    // The serializer strobe is only ever high in RTX, so the line is owned
    // exactly while the byte is going out.
    assign bus_data              = w_tx_valid ? w_tx_bit : 1'bz;
    assign bif.bus_data_in_valid = w_tx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_addr_sh    <= '0;
            r_data_sh    <= '0;
            r_wait_cnt   <= '0;
            r_rdata      <= '0;
            r_have_data  <= 1'b0;
            target_addr  <= '0;
            target_wdata <= '0;
            target_wr    <= 1'b0;
            target_rd    <= 1'b0;
            target_ack   <= 1'b0;
            target_split <= 1'b0;
        end else begin
            target_wr    <= 1'b0;
            target_rd    <= 1'b0;
            target_ack   <= 1'b0;
            target_split <= 1'b0;

            case (r_state)
                S_IDLE, S_ADDR: begin
                    if (w_addr_stb) begin
                        if (r_bit_cnt == BCNT_W'(ADDR_W - 1)) begin
                            r_bit_cnt <= '0;
                            r_addr_sh <= '0;
                            if (w_addr_full[TID_MSB:TID_LSB] == TARGET_ID) begin
                                target_addr <= w_addr_full;
                                if (bif.bus_init_rw) begin
                                    r_state <= S_WDATA;
                                end else begin
                                    r_state     <= S_RWAIT;
                                    target_rd   <= 1'b1;
                                    r_wait_cnt  <= '0;
                                    r_have_data <= 1'b0;
                                end
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_addr_sh <= {bus_data, r_addr_sh[ADDR_W-2:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_state   <= S_ADDR;
                        end
                    end
                end

                S_WDATA: begin
                    if (w_data_stb) begin
                        if (r_bit_cnt == BCNT_W'(DATA_W - 1)) begin
                            target_wdata <= w_data_full;
                            target_wr    <= 1'b1;
                            r_bit_cnt    <= '0;
                            r_data_sh    <= '0;
                            r_state      <= S_WRITE;
                        end else begin
                            r_data_sh <= {bus_data, r_data_sh[DATA_W-2:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end

                S_WRITE: begin
                    target_ack <= 1'b1;
                    r_state    <= S_ACK;
                end

                S_RWAIT: begin
                    // Data arriving on the last waiting cycle still beats the split
                    if (target_rdata_valid) begin
                        r_state <= S_RTX;
                    end else if (r_wait_cnt == CNT_W'(SPLIT_TIMEOUT - 1)) begin
                        r_wait_cnt   <= '0;
                        target_split <= 1'b1;
                        r_state      <= S_SPLIT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                S_SPLIT: begin
                    if (w_ser_load) begin
                        r_have_data <= 1'b0;
                        r_state     <= S_RTX;
                    end else if (target_rdata_valid) begin
                        r_rdata     <= target_rdata;
                        r_have_data <= 1'b1;
                    end
                end

                S_RTX: begin
                    if (w_tx_last) begin
                        target_ack <= 1'b1;
                        r_state    <= S_ACK;
                    end
                end

                S_ACK: begin
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_target_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_target_port
// Purpose  : Self-checking bench for target_port. Each transaction task works
//            out, from the protocol timing rules, which cycle every output
//            strobe must appear in and records it in per-cycle expectation
//            tables; a single compare process checks every DUT output against
//            those tables on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_target_port;

    localparam logic [3:0] TID  = 4'h1;
    localparam int         TMO  = 8;
    localparam int         MAXC = 16384;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    wire         bus_data;
    logic        drv_en = 1'b0;
    logic        drv_bit = 1'b0;
    logic [7:0]  target_rdata = 8'h00;
    logic        target_rdata_valid = 1'b0;
    logic [15:0] target_addr;
    logic [7:0]  target_wdata;
    logic        target_wr, target_rd, target_ack, target_split;

    assign bus_data = drv_en ? drv_bit : 1'bz;

    target_port_if bif ();

    target_port #(.TARGET_ID(TID), .SPLIT_TIMEOUT(TMO)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .bus_data           (bus_data),
        .bif                (bif),
        .target_rdata       (target_rdata),
        .target_rdata_valid (target_rdata_valid),
        .target_addr        (target_addr),
        .target_wdata       (target_wdata),
        .target_wr          (target_wr),
        .target_rd          (target_rd),
        .target_ack         (target_ack),
        .target_split       (target_split)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle expectations (zero means the strobe must be low)
    bit          e_wr [MAXC];
    bit          e_rd [MAXC];
    bit          e_ack[MAXC];
    bit          e_spl[MAXC];
    bit          e_inv[MAXC];
    bit          e_bit[MAXC];
    logic [15:0] e_addr [MAXC];
    logic [7:0]  e_wdata[MAXC];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wr_cnt = 0, rd_cnt = 0, ack_cnt = 0, spl_cnt = 0;
    logic [15:0] last_wr_addr = '0;
    logic [7:0]  last_wr_data = '0;
    logic [7:0]  rx_sh = '0;
    int          rx_n = 0;
    logic [7:0]  last_rx = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic compare_forever();
        forever begin
            @(negedge clk);
            if (cyc < MAXC) begin
                check("wr",    32'(target_wr),             32'(e_wr[cyc]));
                check("rd",    32'(target_rd),             32'(e_rd[cyc]));
                check("ack",   32'(target_ack),            32'(e_ack[cyc]));
                check("split", 32'(target_split),          32'(e_spl[cyc]));
                check("inval", 32'(bif.bus_data_in_valid), 32'(e_inv[cyc]));
                if (e_wr[cyc]) begin
                    check("wr_addr",  32'(target_addr),  32'(e_addr[cyc]));
                    check("wr_wdata", 32'(target_wdata), 32'(e_wdata[cyc]));
                end
                if (e_rd[cyc]) check("rd_addr", 32'(target_addr), 32'(e_addr[cyc]));
                if (e_inv[cyc]) check("tx_bit", 32'(bus_data), 32'(e_bit[cyc]));
            end
            if (target_wr) begin
                wr_cnt++;
                last_wr_addr = target_addr;
                last_wr_data = target_wdata;
            end
            if (target_rd)    rd_cnt++;
            if (target_ack)   ack_cnt++;
            if (target_split) spl_cnt++;
            if (bif.bus_data_in_valid) begin
                rx_sh = {bus_data, rx_sh[7:1]};
                rx_n++;
                if (rx_n == 8) begin
                    last_rx = rx_sh;
                    rx_n    = 0;
                end
            end
        end
    endtask

    task automatic idle_cycle();
        bif.bus_data_out_valid = 1'b0;
        bif.split_grant        = 1'b0;
        target_rdata_valid     = 1'b0;
        drv_en                 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic strobe(input bit b, input bit mode);
        bif.bus_data_out_valid = 1'b1;
        bif.bus_mode           = mode;
        drv_en                 = 1'b1;
        drv_bit                = b;
        @(posedge clk); #1;
        bif.bus_data_out_valid = 1'b0;
        drv_en                 = 1'b0;
    endtask

    // Random idle gap, optionally sprinkled with strobes the target must ignore
    task automatic gap(input int gapmax, input bit noise, input bit nmode);
        int n;
        n = $urandom_range(gapmax, 0);
        for (int j = 0; j < n; j++) begin
            if (noise && $urandom_range(1, 0) == 1) strobe(1'($urandom), nmode);
            else idle_cycle();
        end
    endtask

    task automatic send_addr(input logic [15:0] a, input bit rw, input int gapmax,
                             input bit noise, output int last);
        bif.bus_init_rw = rw;
        last = cyc;
        for (int i = 0; i < 16; i++) begin
            gap(gapmax, noise, 1'b1);
            last = cyc;
            strobe(a[i], 1'b0);
        end
    endtask

    // Write: target_wr one cycle after the last data bit, ack one cycle later
    task automatic do_write(input logic [15:0] a, input logic [7:0] d,
                            input int gapmax, input bit noise);
        int last;
        bit hit;
        hit = (a[15:12] == TID);
        send_addr(a, 1'b1, gapmax, noise, last);
        for (int i = 0; i < 8; i++) begin
            gap(gapmax, noise && hit, 1'b0);
            last = cyc;
            strobe(d[i], 1'b1);
        end
        if (hit) begin
            e_wr[last+1]    = 1'b1;
            e_addr[last+1]  = a;
            e_wdata[last+1] = d;
            e_ack[last+2]   = 1'b1;
        end
        while (cyc <= last + 2) idle_cycle();
    endtask

    // Read: target_rd the cycle after the last address bit. Data offered
    // within the first TMO waiting cycles is returned directly; otherwise a
    // split pulse follows TMO cycles after target_rd and the byte returns
    // after the first grant that finds data captured.
    task automatic do_read(input logic [15:0] a, input int lat, input logic [7:0] d,
                           input int vdly, input int gdly, input int gapmax, input bit noise);
        int last, t0, v, g, s, tx;
        bit in_rtx;
        send_addr(a, 1'b0, gapmax, noise, last);
        if (a[15:12] != TID) begin
            repeat (2) idle_cycle();
            return;
        end
        t0 = last + 1;
        e_rd[t0]   = 1'b1;
        e_addr[t0] = a;
        if (lat < TMO) begin
            s  = -1;
            v  = t0 + lat;
            g  = -1;
            tx = v;
        end else begin
            s  = t0 + TMO;
            e_spl[s] = 1'b1;
            v  = s + vdly;
            g  = v + gdly;
            tx = g;
        end
        for (int i = 0; i < 8; i++) begin
            e_inv[tx+1+i] = 1'b1;
            e_bit[tx+1+i] = d[i];
        end
        e_ack[tx+9] = 1'b1;
        while (cyc <= tx + 9) begin
            in_rtx                 = noise && (cyc > tx);
            target_rdata_valid     = (cyc == v) || (in_rtx && $urandom_range(1, 0) == 1);
            target_rdata           = (cyc == v) ? d : 8'($urandom);
            bif.split_grant        = (cyc == g) || (s >= 0 && vdly > 0 && cyc == s);
            bif.bus_data_out_valid = in_rtx && $urandom_range(1, 0) == 1;
            bif.bus_mode           = 1'($urandom);
            @(posedge clk); #1;
        end
        idle_cycle();
    endtask

    initial begin
        int          w0, r0, a0, s0;
        logic [15:0] ra;
        logic [3:0]  tid;
        bif.bus_data_out_valid = 1'b0;
        bif.bus_mode           = 1'b0;
        bif.bus_init_rw        = 1'b0;
        bif.split_grant        = 1'b0;
        fork compare_forever(); join_none

        rst_n = 1'b0;
        repeat (3) idle_cycle();
        check("reset_addr",  32'(target_addr),  32'h0);
        check("reset_wdata", 32'(target_wdata), 32'h0);
        rst_n = 1'b1;
        idle_cycle();

        // Contiguous write
        do_write(16'h1234, 8'hA5, 0, 1'b0);
        check("w1234_addr", 32'(last_wr_addr), 32'h1234);
        check("w1234_data", 32'(last_wr_data), 32'hA5);

        // Wrong target ID, write then read: nothing may happen
        w0 = wr_cnt; r0 = rd_cnt; a0 = ack_cnt;
        do_write(16'h2000, 8'h77, 0, 1'b0);
        do_read(16'h2000, 2, 8'h11, 0, 0, 0, 1'b0);
        check("mis_wr",  32'(wr_cnt),  32'(w0));
        check("mis_rd",  32'(rd_cnt),  32'(r0));
        check("mis_ack", 32'(ack_cnt), 32'(a0));

        // Direct read, data two cycles after target_rd
        s0 = spl_cnt;
        do_read(16'h1010, 2, 8'h3C, 0, 0, 0, 1'b0);
        check("r3c_byte",  32'(last_rx), 32'h3C);
        check("r3c_split", 32'(spl_cnt), 32'(s0));

        // Split read
        do_read(16'h1ABC, TMO, 8'h81, 2, 1, 0, 1'b0);
        check("r81_byte",  32'(last_rx), 32'h81);
        check("r81_split", 32'(spl_cnt), 32'(s0 + 1));

        // Reset part way through an address, then a clean write
        bif.bus_init_rw = 1'b1;
        for (int i = 0; i < 9; i++) strobe(i[0], 1'b0);
        rst_n = 1'b0;
        idle_cycle();
        check("midrst_addr", 32'(target_addr), 32'h0);
        idle_cycle();
        rst_n = 1'b1;
        idle_cycle();
        w0 = wr_cnt;
        do_write(16'h1FFF, 8'h55, 0, 1'b0);
        check("rst_wr_cnt", 32'(wr_cnt),       32'(w0 + 1));
        check("rst_addr",   32'(last_wr_addr), 32'h1FFF);
        check("rst_data",   32'(last_wr_data), 32'h55);

        // Gapped write with mode=1 noise during the address phase
        do_write(16'h1234, 8'hA5, 3, 1'b1);
        check("gap_addr", 32'(last_wr_addr), 32'h1234);
        check("gap_data", 32'(last_wr_data), 32'hA5);

        // Randomized mix
        for (int t = 0; t < 40; t++) begin
            tid = ($urandom_range(4, 0) != 0) ? TID : 4'($urandom);
            ra  = {tid, 12'($urandom)};
            if ($urandom_range(1, 0) == 1)
                do_write(ra, 8'($urandom), $urandom_range(2, 0), 1'($urandom));
            else
                do_read(ra, $urandom_range(12, 0), 8'($urandom), $urandom_range(3, 0),
                        $urandom_range(3, 0), $urandom_range(2, 0), 1'($urandom));
            gap(2, 1'b0, 1'b0);
        end

        repeat (3) idle_cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/target_port.md
TARGET_PORT -- requirements
Module: target_port

Interface
REQ-001 Parameter TARGET_ID, default 4'h1: value that addr[15:12] must match for this target to respond.
REQ-002 Parameter SPLIT_TIMEOUT, default 8: number of cycles to wait for read data before a split is signalled.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 bus_data  inout  1  serial bus line; sampled on receive, driven only while transmitting, else 1'bz.
REQ-006 bus_data_out_valid  input  1  initiator bit strobe; bus_data holds a valid bit this cycle.
REQ-007 bus_mode  input  1  0 = address phase, 1 = data phase.
REQ-008 bus_init_rw  input  1  1 = write, 0 = read; sampled at address completion.
REQ-009 split_grant  input  1  bus re-granted for split read return.
REQ-010 target_rdata  input  8  read data from local memory.
REQ-011 target_rdata_valid  input  1  target_rdata valid, single-cycle pulse.
REQ-012 target_addr  output  16  latched address.
REQ-013 target_wdata  output  8  assembled write data.
REQ-014 target_wr  output  1  one-cycle write strobe.
REQ-015 target_rd  output  1  one-cycle read-request strobe.
REQ-016 bus_data_in_valid  output  1  strobe marking a bit this port drives onto bus_data.
REQ-017 target_ack  output  1  one-cycle transaction-complete pulse.
REQ-018 target_split  output  1  one-cycle split pulse.

Function
REQ-019 Serial format: LSB first, one bit per strobed cycle; address 16 bits, data 8 bits; gaps between strobes hold the bit counter.
REQ-020 FSM states: IDLE, ADDR, WDATA, WRITE, RWAIT, SPLIT, RTX, ACK.
REQ-021 IDLE/ADDR: each strobe with bus_mode=0 shifts one address bit; strobes with bus_mode=1 are ignored; on the 16th bit, go to WDATA if bus_init_rw=1, else RWAIT; if addr[15:12]!=TARGET_ID, discard and return to IDLE with no strobes.
REQ-022 WDATA: accept strobes with bus_mode=1 only; after the 8th bit, go to WRITE.
REQ-023 WRITE: target_wr=1 for exactly one cycle with target_addr/target_wdata stable, then go to ACK.
REQ-024 RWAIT: target_rd=1 on the entry cycle only; count cycles; on target_rdata_valid, capture data and go to RTX; if the count reaches SPLIT_TIMEOUT with no data, go to SPLIT.
REQ-025 SPLIT: target_split=1 on the entry cycle only; capture target_rdata on target_rdata_valid; go to RTX on the first cycle where data is captured and split_grant=1.
REQ-026 RTX: drive 8 bits LSB first on consecutive cycles with bus_data_in_valid=1, bit and strobe registered and aligned; release the bus after the 8th bit; go to ACK.
REQ-027 ACK: target_ack=1 for one cycle, then go to IDLE; write latency is 2 cycles after the last data bit.
REQ-028 bus_data_out_valid during RTX, RWAIT, SPLIT or ACK: ignored.
REQ-029 target_rdata_valid outside RWAIT/SPLIT: ignored.
REQ-030 bus_data is driven only in RTX; never driven from any other state.

Reset
REQ-031 rst_n low: state=IDLE, counters=0, target_addr=0, target_wdata=0, all strobes=0, bus released; this applies mid-transaction, and any partial bits are discarded.

Structure
REQ-032 bus_pkg holds ADDR_W=16, DATA_W=8, the state enum, and the TARGET_ID field position [15:12].
REQ-033 One sub-module, target_serializer: 8-bit load-and-shift transmitter producing the bus_data drive value and bus_data_in_valid.

Verification
REQ-034 Write: addr 0x1234 then data 0xA5, contiguous strobes -> target_wr one cycle with addr 0x1234, wdata 0xA5; target_ack 1 cycle later.
REQ-035 Mismatch: addr 0x2000 with TARGET_ID=1 -> no target_wr, target_rd or target_ack; FSM back in IDLE.
REQ-036 Read: addr 0x1010, rdata 0x3C valid 2 cycles after target_rd -> bits 0,0,1,1,1,1,0,0 with 8 strobes, then target_ack; no split.
REQ-037 Split: no rdata for 8 cycles -> target_split pulse; rdata 0x81 then split_grant -> 0x81 serialized, target_ack.
REQ-038 Reset after 9 address bits, then a full write 0x1FFF/0x55 -> only the second transaction is performed.
REQ-039 Gapped write with random idle cycles between strobes, plus bus_mode=1 noise during the address phase -> same result as REQ-034.
